ld_st_mem_unit: RTL and testbench

- Synchronous single-port word memory that services the load and store operations issued by the generated datapath.
- Sits directly downstream of the load/store builtins.
- Accepts one request per cycle over a valid/ready channel.
- Returns load data through a 2-entry response FIFO, so the datapath can stall on the response side without losing data.
- Stores produce no response.

---
 rtl/ld_st_mem_unit_pkg.sv | 22 ++
 rtl/ld_st_mem_unit_resp_fifo_2.sv | 84 ++++++++
 rtl/ld_st_mem_unit.sv | 78 +++++++
 tb/tb_ld_st_mem_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ld_st_mem_unit_pkg.sv
// ---------------------------------------------------------------------------
// ld_st_mem_unit_pkg
// Shared definitions for the load/store memory unit and its response FIFO.
//   RSP_FIFO_DEPTH : number of response slots (fixed at 2)
//   fifo_cnt_t     : occupancy counter type (0..2)
//   ptr_inc        : next value of a 1-bit circular pointer
// ---------------------------------------------------------------------------
package ld_st_mem_unit_pkg;

    localparam int RSP_FIFO_DEPTH = 2;

    typedef logic [1:0] fifo_cnt_t;

    localparam fifo_cnt_t FIFO_CNT_FULL  = 2'd2;
    localparam fifo_cnt_t FIFO_CNT_EMPTY = 2'd0;

    // With two slots the pointer simply toggles.
    function automatic logic ptr_inc(input logic ptr);
        return ~ptr;
    endfunction

endpackage

// File: rtl/ld_st_mem_unit_resp_fifo_2.sv
// ---------------------------------------------------------------------------
// resp_fifo_2
// Two-entry circular FIFO holding load responses.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   push       : write push_data into the tail (ignored when full)
//   push_data  : data to enqueue
//   pop        : drop the head entry (ignored when empty)
//   full       : both slots occupied
//   empty      : no slots occupied
//   head       : registered data at the head slot
// Entry storage is cleared on reset so head never shows X for a slot that
// has not been written since reset.
// ---------------------------------------------------------------------------
module resp_fifo_2
    import ld_st_mem_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] entry_q [RSP_FIFO_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    fifo_cnt_t        count_q, count_d;
    logic             push_en;
    logic             pop_en;

    assign full    = (count_q == FIFO_CNT_FULL);
    assign empty   = (count_q == FIFO_CNT_EMPTY);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign head    = entry_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_en) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_en, pop_en})
            2'b10:   count_d = fifo_cnt_t'(count_q + 2'd1);
            2'b01:   count_d = fifo_cnt_t'(count_q - 2'd1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= FIFO_CNT_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < RSP_FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_q[gi] <= '0;
                end else if (push_en && (int'(wr_ptr_q) == gi)) begin
                    entry_q[gi] <= push_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/ld_st_mem_unit.sv
// ---------------------------------------------------------------------------
// ld_st_mem_unit
// Single-port word memory servicing load/store requests from the datapath.
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   req_valid    : request present
//   req_ready    : unit can accept a request (depends on registered state only)
//   req_is_store : 1 = store, 0 = load
//   req_addr     : word address
//   req_wdata    : store data (ignored for loads)
//   rsp_valid    : load response available at FIFO head
//   rsp_ready    : consumer takes the head entry
//   rsp_rdata    : load data at FIFO head
// Loads read the array contents as they stand before the accepting edge and
// enqueue them on that same edge, giving a one-cycle response latency when
// the FIFO is empty. Stores write on the accepting edge and produce no
// response. The memory array itself is not reset.
// DEPTH must be a power of two, minimum 2.
// ---------------------------------------------------------------------------
module ld_st_mem_unit
    import ld_st_mem_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             accept;
    logic             load_push;
    logic             rsp_pop;
    logic [WIDTH-1:0] load_data;
    logic             fifo_full;
    logic             fifo_empty;

    // Back-pressure comes purely from FIFO occupancy, so a pop in a full
    // cycle only re-opens the request side on the following cycle.
    assign req_ready = ~fifo_full;
    assign rsp_valid = ~fifo_empty;
    assign accept    = req_valid & req_ready;
    assign rsp_pop   = rsp_valid & rsp_ready;
    assign load_push = accept & ~req_is_store;

    // Asynchronous array read: the pre-edge value is captured by the FIFO
    // on the accepting edge, so a store followed next cycle by a load of the
    // same address sees the new data.
    assign load_data = mem_q[req_addr];

    always_ff @(posedge clk) begin
        if (accept && req_is_store) begin
            mem_q[req_addr] <= req_wdata;
        end
    end

    resp_fifo_2 #(
        .WIDTH (WIDTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (load_push),
        .push_data (load_data),
        .pop       (rsp_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (rsp_rdata)
    );

endmodule

// File: tb/tb_ld_st_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_ld_st_mem_unit
// Directed bench for ld_st_mem_unit. Inputs change 1 ns after a rising edge;
// outputs are checked at that point (post-edge state) before the next edge.
// ---------------------------------------------------------------------------
module tb_ld_st_mem_unit;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_is_store;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_rdata;

    int checks = 0;
    int errors = 0;

    ld_st_mem_unit #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        req_valid    = 1'b1;
        req_is_store = 1'b1;
        req_addr     = a;
        req_wdata    = d;
        $display("[%0t] store addr=%0d data=0x%08h", $time, a, d);
    endtask

    task automatic drive_load(input logic [AW-1:0] a);
        req_valid    = 1'b1;
        req_is_store = 1'b0;
        req_addr     = a;
        req_wdata    = '0;
        $display("[%0t] load  addr=%0d", $time, a);
    endtask

    task automatic drive_idle();
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        rsp_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        checks++;
        if (rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rsp_rdata: got 0x%08h expected 0x00000000", rsp_rdata);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: got valid=%b ready=%b expected valid=0 ready=1",
                     rsp_valid, req_ready);
        end
    endtask

    task automatic test_store_load();
        rsp_ready = 1'b1;
        drive_store(4'd3, 32'hDEADBEEF);
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_no_rsp: got rsp_valid=%b expected 0", rsp_valid);
        end
        drive_load(4'd3);
        tick();
        drive_idle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_load_rsp: got valid=%b data=0x%08h expected valid=1 data=0xdeadbeef",
                     rsp_valid, rsp_rdata);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL store_load_popped: got rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_back_pressure();
        rsp_ready = 1'b0;
        drive_store(4'd1, 32'h11);
        tick();
        drive_store(4'd2, 32'h22);
        tick();
        drive_load(4'd1);
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first_load: got valid=%b data=0x%08h ready=%b expected 1/0x11/1",
                     rsp_valid, rsp_rdata, req_ready);
        end
        drive_load(4'd2);
        tick();
        checks++;
        if (req_ready !== 1'b0 || rsp_rdata !== 32'h11) begin
            errors++;
            $display("FAIL bp_full: got ready=%b data=0x%08h expected 0/0x11",
                     req_ready, rsp_rdata);
        end
        drive_load(4'd1);
        tick();
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h11) begin
            errors++;
            $display("FAIL bp_held: got ready=%b valid=%b data=0x%08h expected 0/1/0x11",
                     req_ready, rsp_valid, rsp_rdata);
        end
        // First pop happens here; the held load was not accepted at this edge.
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h22 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_pop1: got valid=%b data=0x%08h ready=%b expected 1/0x22/1",
                     rsp_valid, rsp_rdata, req_ready);
        end
        // Held load accepted while 0x22 pops.
        tick();
        drive_idle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11) begin
            errors++;
            $display("FAIL bp_pop2: got valid=%b data=0x%08h expected 1/0x11",
                     rsp_valid, rsp_rdata);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained: got rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_streaming();
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_store(AW'(i), 32'h100 + 32'(i));
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive_load(AW'(i));
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== (32'h100 + 32'(i)) || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d: got valid=%b data=0x%08h ready=%b expected 1/0x%08h/1",
                         i, rsp_valid, rsp_rdata, req_ready, 32'h100 + 32'(i));
            end
        end
        drive_idle();
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_end: got rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        rsp_ready = 1'b0;
        drive_load(4'd3);
        tick();
        drive_load(4'd4);
        tick();
        drive_idle();
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 32'h103) begin
            errors++;
            $display("FAIL midrst_pending: got valid=%b ready=%b data=0x%08h expected 1/0/0x103",
                     rsp_valid, req_ready, rsp_rdata);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midrst_async: got valid=%b ready=%b data=0x%08h expected 0/1/0",
                     rsp_valid, req_ready, rsp_rdata);
        end
        tick();
        rst_n = 1'b1;
        tick();
        rsp_ready = 1'b1;
        drive_load(4'd5);
        tick();
        drive_idle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h105) begin
            errors++;
            $display("FAIL midrst_retained: got valid=%b data=0x%08h expected 1/0x105",
                     rsp_valid, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_store_while_full();
        rsp_ready = 1'b0;
        drive_load(4'd6);
        tick();
        drive_load(4'd7);
        tick();
        drive_store(4'd6, 32'hCAFE);
        tick();
        checks++;
        if (req_ready !== 1'b0 || rsp_rdata !== 32'h106) begin
            errors++;
            $display("FAIL full_store_blocked: got ready=%b data=0x%08h expected 0/0x106",
                     req_ready, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1 || rsp_rdata !== 32'h107 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_store_pop: got ready=%b valid=%b data=0x%08h expected 1/1/0x107",
                     req_ready, rsp_valid, rsp_rdata);
        end
        // Store accepted here while 0x107 pops; no response is produced.
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_store_norsp: got rsp_valid=%b expected 0", rsp_valid);
        end
        drive_load(4'd6);
        tick();
        drive_idle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE) begin
            errors++;
            $display("FAIL full_store_written: got valid=%b data=0x%08h expected 1/0x0000cafe",
                     rsp_valid, rsp_rdata);
        end
        // Address 7 must still hold its earlier value.
        drive_load(4'd7);
        tick();
        drive_idle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h107) begin
            errors++;
            $display("FAIL full_store_neighbour: got valid=%b data=0x%08h expected 1/0x107",
                     rsp_valid, rsp_rdata);
        end
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        drive_idle();
        test_reset();
        test_store_load();
        test_back_pressure();
        test_streaming();
        test_reset_mid_op();
        test_store_while_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
